// File: rtl/acq_pkg.sv
// Shared definitions for the acquisition controller: mode encoding,
// controller state names and the default sample-buffer depth.
package acq_pkg;

  localparam int SAMPLE_DEPTH_DEF = 8;

  localparam logic [1:0] MODE_STOP   = 2'd0;
  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_NORMAL = 2'd2;
  localparam logic [1:0] MODE_AUTO   = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    RELEASE,
    FETCH,
    WAIT,
    SEND,
    DONE
  } state_t;

endpackage

// File: rtl/acq_if.sv
// Byte stream from the acquisition controller to the host transmitter.
interface acq_if;

  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for signals arriving from a slower clock domain.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  // Shift the asynchronous input through two flops before anyone uses it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/acq_controller.sv
// Frame sequencer: arms the sampler, waits for its capture, then reads the
// circular sample buffer back oldest-first and streams it to the host.
module acq_controller
  import acq_pkg::*;
#(
  parameter int SAMPLE_DEPTH = SAMPLE_DEPTH_DEF,
  parameter int AUTO_TIMEOUT = 50000000,
  parameter int TIMEOUT_W    = 26
) (
  input  logic                    clk_50mhz,
  input  logic                    reset,
  input  logic [1:0]              mode,
  input  logic                    arm,
  input  logic                    stop,
  output logic                    busy,
  output logic                    forced,
  output logic [15:0]             frame_count,
  output logic                    sampler_activate,
  input  logic                    sampler_done,
  input  logic [SAMPLE_DEPTH-1:0] sampler_offset,
  output logic                    sampler_force_trig,
  output logic                    mem_sel,
  output logic [SAMPLE_DEPTH-1:0] rd_addr,
  output logic                    rd_en,
  input  logic [7:0]              rd_data,
  acq_if.master                   host
);

  localparam logic [SAMPLE_DEPTH-1:0] L_HALF = SAMPLE_DEPTH'(1) << (SAMPLE_DEPTH - 1);
  localparam logic [TIMEOUT_W-1:0]    L_TMAX = TIMEOUT_W'(AUTO_TIMEOUT - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [SAMPLE_DEPTH-1:0] r_offset;
  logic [SAMPLE_DEPTH-1:0] r_idx;
  logic [TIMEOUT_W-1:0]    r_timer;
  logic                    r_forceTrig;
  logic                    r_forced;
  logic                    r_abort;
  logic                    r_stopPending;
  logic                    r_halted;
  logic                    r_armReq;
  logic [1:0]              r_mode;
  logic [7:0]              r_outData;
  logic [15:0]             r_frameCount;
  logic                    w_doneS;
  logic                    w_last;
  logic                    w_contMode;
  logic                    w_startReq;
  logic                    w_doneStop;
  logic [SAMPLE_DEPTH-1:0] w_addr;

  sync_2ff #(.W(1)) u_doneSync (
    .clk (clk_50mhz),
    .rst (reset),
    .i_d (sampler_done),
    .o_q (w_doneS)
  );

  // The trigger sample sits half a buffer after the oldest one, so the
  // readout starts at offset + half and wraps around the buffer.
  assign w_addr     = r_offset + L_HALF + r_idx;
  assign w_last     = (r_idx == '1);
  assign w_contMode = (mode == MODE_NORMAL) || (mode == MODE_AUTO);
  // r_halted keeps a stopped NORMAL/AUTO run from re-arming by itself until
  // the mode is moved to STOP or SINGLE.
  assign w_startReq = !stop && (r_armReq || ((mode == MODE_SINGLE) && arm) || (w_contMode && !r_halted));
  assign w_doneStop = (mode == MODE_STOP) || (mode == MODE_SINGLE) || r_stopPending || stop;

  // Next-state selection and decoding of the state-driven outputs.
  always_comb begin
    w_next           = r_state;
    busy             = (r_state != IDLE);
    sampler_activate = 1'b0;
    mem_sel          = 1'b0;
    rd_en            = 1'b0;
    rd_addr          = '0;
    host.out_valid   = 1'b0;
    host.out_last    = 1'b0;
    case (r_state)
      IDLE:    if (w_startReq && !w_doneS) w_next = ARM;
      ARM: begin
        sampler_activate = 1'b1;
        if (w_doneS) w_next = RELEASE;
      end
      RELEASE: if (!w_doneS) w_next = r_abort ? IDLE : FETCH;
      FETCH: begin
        mem_sel = 1'b1;
        rd_en   = 1'b1;
        rd_addr = w_addr;
        w_next  = WAIT;
      end
      WAIT: begin
        mem_sel = 1'b1;
        w_next  = SEND;
      end
      SEND: begin
        mem_sel        = 1'b1;
        host.out_valid = 1'b1;
        host.out_last  = w_last;
        if (host.out_ready) w_next = w_last ? DONE : FETCH;
      end
      DONE:    w_next = w_doneStop ? IDLE : ARM;
      default: w_next = IDLE;
    endcase
  end

  assign host.out_data      = r_outData;
  assign sampler_force_trig = r_forceTrig;
  assign forced             = r_forced;
  assign frame_count        = r_frameCount;

  // State register plus the per-state bookkeeping: timeout, force/abort
  // flags, offset latch, readout index, output byte and frame counter.
  always_ff @(posedge clk_50mhz or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_offset      <= '0;
      r_idx         <= '0;
      r_timer       <= '0;
      r_forceTrig   <= 1'b0;
      r_forced      <= 1'b0;
      r_abort       <= 1'b0;
      r_stopPending <= 1'b0;
      r_halted      <= 1'b0;
      r_armReq      <= 1'b0;
      r_mode        <= MODE_STOP;
      r_outData     <= '0;
      r_frameCount  <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if ((mode == MODE_STOP) || (mode == MODE_SINGLE)) r_halted <= 1'b0;
          if (stop) begin
            r_armReq <= 1'b0;
            r_halted <= 1'b1;
          end else if ((mode == MODE_SINGLE) && arm) begin
            r_armReq <= 1'b1;
          end
          if (w_next == ARM) begin
            r_armReq <= 1'b0;
            r_mode   <= mode;
            r_forced <= 1'b0;
            r_timer  <= '0;
          end
        end
        ARM: begin
          if (r_timer != L_TMAX) r_timer <= r_timer + TIMEOUT_W'(1);
          if ((r_mode == MODE_AUTO) && (r_timer == L_TMAX)) begin
            r_forceTrig <= 1'b1;
            r_forced    <= 1'b1;
          end
          // The sampler cannot abandon a pre-trigger capture, so a stop
          // forces a trigger and the captured frame is dropped afterwards.
          if (stop || (mode == MODE_STOP)) begin
            r_forceTrig <= 1'b1;
            r_forced    <= 1'b1;
            r_abort     <= 1'b1;
          end
          if (w_doneS) begin
            r_offset    <= sampler_offset;
            r_forceTrig <= 1'b0;
          end
        end
        RELEASE: begin
          r_forceTrig <= 1'b0;
          if (stop) r_stopPending <= 1'b1;
          if (w_next == IDLE) begin
            r_abort       <= 1'b0;
            r_halted      <= 1'b1;
            r_stopPending <= 1'b0;
          end
          if (w_next == FETCH) r_idx <= '0;
        end
        FETCH: if (stop) r_stopPending <= 1'b1;
        WAIT: begin
          r_outData <= rd_data;
          if (stop) r_stopPending <= 1'b1;
        end
        SEND: begin
          if (stop) r_stopPending <= 1'b1;
          if (host.out_ready) begin
            r_idx <= r_idx + SAMPLE_DEPTH'(1);
            if (w_last) r_frameCount <= r_frameCount + 16'd1;
          end
        end
        DONE: begin
          if (w_next == IDLE) begin
            r_stopPending <= 1'b0;
            if (r_stopPending || stop) r_halted <= 1'b1;
          end else begin
            r_mode   <= mode;
            r_forced <= 1'b0;
            r_timer  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/acq_controller.md
Name: acq_controller

Overview:
- Sequences one sampler capture per frame: activate/done handshake, offset latch, auto-mode force trigger.
- Owns the sample-memory mux: sampler writes during capture, controller reads during readout.
- Reads the circular buffer back oldest-first and streams bytes on a valid/ready port to the host link (UART tx).
- Sits between the mode/command registers, the sampler, the sample RAM and the host transmitter.

Parameters:
SAMPLE_DEPTH, 8, address width; buffer holds 2^SAMPLE_DEPTH samples
AUTO_TIMEOUT, 50000000, clk_50mhz cycles in ARM before AUTO mode forces a trigger
TIMEOUT_W, 26, width of the timeout counter; must satisfy 2^TIMEOUT_W > AUTO_TIMEOUT

Ports:
clk_50mhz  in  1  single system clock; all logic on its rising edge
reset  in  1  asynchronous, active-high reset
mode  in  2  0 STOP, 1 SINGLE, 2 NORMAL, 3 AUTO
arm  in  1  one-cycle pulse; starts a SINGLE capture
stop  in  1  one-cycle pulse; abort or finish, then go IDLE
busy  out  1  high in every state except IDLE
forced  out  1  last frame was triggered by the AUTO timeout or by stop
frame_count  out  16  frames fully streamed; wraps
sampler_activate  out  1  to sampler activate
sampler_done  in  1  from sampler done; slow-clock domain
sampler_offset  in  SAMPLE_DEPTH  trigger address; stable while done is high
sampler_force_trig  out  1  to sampler force_trig
mem_sel  out  1  0 = sampler owns RAM, 1 = controller owns RAM
rd_addr  out  SAMPLE_DEPTH  RAM read address
rd_en  out  1  RAM read enable; data valid one cycle later
rd_data  in  8  RAM read data
out_data  out  8  stream byte
out_valid  out  1  stream valid
out_ready  in  1  stream ready
out_last  out  1  high with the final byte of a frame

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, offset register 0. Reset mid-frame drops activate immediately; the next ARM first waits for synchronized done to be low.
- sampler_done passes through a 2-FF synchronizer (done_s). sampler_offset is latched on the first cycle done_s is high.
- IDLE:
  - Go to ARM on (mode==SINGLE and arm), or when mode is NORMAL/AUTO and stop was not pending.
  - Before entering ARM, wait until done_s==0.
- ARM:
  - sampler_activate=1, mem_sel=0.
  - Timeout counter increments from 0 on entry.
  - In AUTO, when the counter reaches AUTO_TIMEOUT-1, set force_trig and forced. Both stay set until done_s rises; the counter saturates.
  - stop in ARM: set force_trig and an abort flag (needed because the sampler cannot abort pre-trigger).
  - On done_s=1: latch offset and go to RELEASE.
- RELEASE:
  - activate=0, force_trig=0.
  - Wait for done_s=0.
  - If abort is set, go to IDLE (no readout, frame_count unchanged, clear stop_pending). Otherwise go to FETCH with idx=0.
- FETCH: mem_sel=1, rd_en=1, rd_addr = offset + 2^(SAMPLE_DEPTH-1) + idx, truncated to SAMPLE_DEPTH bits (wraps). Then go to WAIT.
- WAIT: one cycle for RAM latency. Register rd_data into out_data, then go to SEND.
- SEND:
  - out_valid=1; out_last = (idx == 2^SAMPLE_DEPTH-1).
  - out_data, out_valid and out_last stay stable until out_ready is seen high.
  - On accept, idx++. If not last, go to FETCH. If last, frame_count++ and go to DONE.
- Stream ordering: output byte index 2^(SAMPLE_DEPTH-1) is the trigger sample; index 0 is the oldest sample.
- DONE:
  - mem_sel=0.
  - Go to IDLE if mode is SINGLE or STOP, or if stop_pending; clear stop_pending on that exit.
  - Otherwise go to ARM; in NORMAL/AUTO the next frame re-arms.
- stop during FETCH/WAIT/SEND sets stop_pending. The frame completes intact, so the host never sees a truncated frame.
- mode changes are sampled only in IDLE and DONE. A change to STOP during ARM acts as stop.
- arm outside IDLE is ignored. arm and stop in the same IDLE cycle: stop wins, no capture.
- forced clears on entry to ARM.
- Throughput: one byte per 3 cycles minimum (FETCH, WAIT, SEND).

Decomposition:
- Shared package acq_pkg:
  - mode encoding (MODE_STOP/SINGLE/NORMAL/AUTO)
  - state enum (IDLE, ARM, RELEASE, FETCH, WAIT, SEND, DONE)
  - SAMPLE_DEPTH default
- Sub-module sync_2ff: the done synchronizer, reusable for trig and other slow-clock signals.
- Address arithmetic and the stream handshake stay inline.

Test Plan:
- SINGLE, offset=0x10, depth 8, out_ready=1:
  - 256 bytes read from addr 0x90,0x91,…,0xFF,0x00,…,0x8F.
  - out_last only on the 256th byte; frame_count=1; then IDLE with busy=0.
- AUTO, AUTO_TIMEOUT=100, sampler model never triggers:
  - force_trig rises exactly 100 cycles after ARM entry and holds until done.
  - forced=1; the frame streams; the controller re-arms automatically.
- out_ready toggled randomly (~30% high): out_data, out_valid and out_last never change while valid=1 and ready=0; byte sequence identical to the ready=1 run.
- stop mid-SEND at byte 40 in NORMAL: all 256 bytes delivered, frame_count+1, then IDLE with no re-arm.
- stop during ARM: force_trig pulses, the sampler finishes, zero bytes emitted, frame_count unchanged, IDLE.
- reset asserted during SEND: all outputs 0 asynchronously; the next SINGLE arm waits for done low before activate, then captures normally.
